// File: rtl/fmcropping.sv
// -----------------------------------------------------------------------------
// fmcropping
//   Feature-map cropping, the inverse of fmpadding. A full (padded) image
//   arrives as an AXI-Stream in raster order (Y outer, X middle, SIMD fold
//   inner). Beats whose pixel lies inside the runtime window
//   [x_on, x_off) x [y_on, y_off) are forwarded unchanged; all other beats are
//   accepted and discarded. The register map matches fmpadding.
//
// Ports
//   ap_clk         clock, all logic on the rising edge
//   ap_rst_n       asynchronous active-low reset
//   we / wa / wd   config write: wa 0 x_on, 1 x_off, 2 x_end,
//                  4 y_on, 5 y_off, 6 y_end (3 and 7 reserved);
//                  wd is truncated to the counter width
//   s_axis_*       input stream (tready / tvalid / tdata)
//   m_axis_*       output stream (tready / tvalid / tdata)
//
// Buffering is an output register (b) plus a skid register (a).
// s_axis_tready depends only on the skid register, so there is no
// combinational path from m_axis_tready to s_axis_tready.
// -----------------------------------------------------------------------------
module fmcropping #(
  parameter int XCOUNTER_BITS = 8,
  parameter int YCOUNTER_BITS = 8,
  parameter int NUM_CHANNELS  = 16,
  parameter int SIMD          = 4,
  parameter int ELEM_BITS     = 8,
  localparam int STREAM_BITS  = 8 * ((SIMD * ELEM_BITS + 7) / 8)
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic                   we,
  input  logic [2:0]             wa,
  input  logic [31:0]            wd,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tvalid,
  input  logic [STREAM_BITS-1:0] s_axis_tdata,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tvalid,
  output logic [STREAM_BITS-1:0] m_axis_tdata
);

  localparam int SF      = NUM_CHANNELS / SIMD;
  localparam int SF_BITS = (SF > 1) ? $clog2(SF) : 1;

  if ((NUM_CHANNELS % SIMD) != 0) begin : g_param_check
    $error("fmcropping: NUM_CHANNELS (%0d) must be a multiple of SIMD (%0d)",
           NUM_CHANNELS, SIMD);
  end

  // Window / extent configuration
  logic [XCOUNTER_BITS-1:0] x_on_reg, x_off_reg, x_end_reg;
  logic [YCOUNTER_BITS-1:0] y_on_reg, y_off_reg, y_end_reg;

  // Raster position of the beat currently presented on s_axis
  logic [SF_BITS-1:0]       s_cnt_reg;
  logic [XCOUNTER_BITS-1:0] x_cnt_reg;
  logic [YCOUNTER_BITS-1:0] y_cnt_reg;

  // Skid (a) and output (b) registers
  logic                   a_vld_reg, b_vld_reg;
  logic [STREAM_BITS-1:0] a_data_reg, b_data_reg;

  logic in_hs;
  logic keep;
  logic b_load;
  logic s_last;
  logic x_last;
  logic y_last;

  assign s_axis_tready = !a_vld_reg;
  assign m_axis_tvalid = b_vld_reg;
  assign m_axis_tdata  = b_data_reg;

  assign in_hs  = s_axis_tvalid && !a_vld_reg;
  assign keep   = (x_cnt_reg >= x_on_reg) && (x_cnt_reg < x_off_reg) &&
                  (y_cnt_reg >= y_on_reg) && (y_cnt_reg < y_off_reg);
  // b may take a new beat when it is empty or being drained this cycle
  assign b_load = !b_vld_reg || m_axis_tready;

  assign s_last = (s_cnt_reg == SF_BITS'(SF - 1));
  assign x_last = (x_cnt_reg == x_end_reg);
  assign y_last = (y_cnt_reg == y_end_reg);

  // Configuration registers
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      x_on_reg  <= '0;
      x_off_reg <= '0;
      x_end_reg <= '0;
      y_on_reg  <= '0;
      y_off_reg <= '0;
      y_end_reg <= '0;
    end else if (we) begin
      case (wa)
        3'd0:    x_on_reg  <= wd[XCOUNTER_BITS-1:0];
        3'd1:    x_off_reg <= wd[XCOUNTER_BITS-1:0];
        3'd2:    x_end_reg <= wd[XCOUNTER_BITS-1:0];
        3'd4:    y_on_reg  <= wd[YCOUNTER_BITS-1:0];
        3'd5:    y_off_reg <= wd[YCOUNTER_BITS-1:0];
        3'd6:    y_end_reg <= wd[YCOUNTER_BITS-1:0];
        default: ;
      endcase
    end
  end

  // Raster counters: advance on every accepted input beat, kept or dropped.
  // The final beat of a frame wraps all three to the origin in the same edge.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s_cnt_reg <= '0;
      x_cnt_reg <= '0;
      y_cnt_reg <= '0;
    end else if (in_hs) begin
      if (!s_last) begin
        s_cnt_reg <= s_cnt_reg + 1'b1;
      end else begin
        s_cnt_reg <= '0;
        if (!x_last) begin
          x_cnt_reg <= x_cnt_reg + 1'b1;
        end else begin
          x_cnt_reg <= '0;
          y_cnt_reg <= y_last ? '0 : y_cnt_reg + 1'b1;
        end
      end
    end
  end

  // Output / skid buffering. When a holds a beat, s_axis_tready is low, so a
  // refill of b from a never coincides with a new input handshake.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      a_vld_reg  <= 1'b0;
      b_vld_reg  <= 1'b0;
      a_data_reg <= '0;
      b_data_reg <= '0;
    end else begin
      if (b_load) begin
        if (a_vld_reg) begin
          b_data_reg <= a_data_reg;
          b_vld_reg  <= 1'b1;
          a_vld_reg  <= 1'b0;
        end else if (in_hs && keep) begin
          b_data_reg <= s_axis_tdata;
          b_vld_reg  <= 1'b1;
        end else begin
          b_vld_reg  <= 1'b0;
        end
      end else if (in_hs && keep) begin
        // b is stalled: park the kept beat in the skid register
        a_data_reg <= s_axis_tdata;
        a_vld_reg  <= 1'b1;
      end
    end
  end

  // Reserved addresses are a software bug; flag them in simulation.
  always @(posedge ap_clk) begin
    if (ap_rst_n && we) begin
      assert (wa[1:0] != 2'b11)
        else $error("fmcropping: write to reserved address %0d (data %h)", wa, wd);
    end
  end

endmodule

// File: tb/tb_fmcropping.sv
module tb_fmcropping;

  localparam int XB   = 8;
  localparam int YB   = 8;
  localparam int NC   = 8;
  localparam int SIMD = 4;
  localparam int EB   = 8;
  localparam int SF   = NC / SIMD;
  localparam int SB   = 8 * ((SIMD * EB + 7) / 8);

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic          we = 1'b0;
  logic [2:0]    wa = '0;
  logic [31:0]   wd = '0;
  logic          s_axis_tready;
  logic          s_axis_tvalid = 1'b0;
  logic [SB-1:0] s_axis_tdata = '0;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tvalid;
  logic [SB-1:0] m_axis_tdata;

  fmcropping #(
    .XCOUNTER_BITS(XB),
    .YCOUNTER_BITS(YB),
    .NUM_CHANNELS (NC),
    .SIMD         (SIMD),
    .ELEM_BITS    (EB)
  ) dut (
    .ap_clk       (ap_clk),
    .ap_rst_n     (ap_rst_n),
    .we           (we),
    .wa           (wa),
    .wd           (wd),
    .s_axis_tready(s_axis_tready),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tdata (s_axis_tdata),
    .m_axis_tready(m_axis_tready),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tdata (m_axis_tdata)
  );

  always #5 ap_clk = ~ap_clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge ap_clk) cyc++;

  // Reference model: window config and beat-index -> keep decision
  int c_xon, c_xoff, c_xend, c_yon, c_yoff, c_yend;

  function automatic int frame_beats();
    return SF * (c_xend + 1) * (c_yend + 1);
  endfunction

  function automatic bit model_keep(int idx);
    int pix, x, y;
    pix = idx / SF;
    x   = pix % (c_xend + 1);
    y   = pix / (c_xend + 1);
    return (x >= c_xon) && (x < c_xoff) && (y >= c_yon) && (y < c_yoff);
  endfunction

  // Scoreboard
  logic [SB-1:0] exp_q[$];
  int            exp_cyc_q[$];
  int            ready_pct = 100;
  bit            chk_latency = 1'b0;
  int            out_cnt = 0;
  int            valid_seen = 0;
  logic [SB-1:0] first_out = '0;
  logic [SB-1:0] last_out = '0;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Output-ready pattern generator
  always @(posedge ap_clk) begin
    #1;
    m_axis_tready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(99) < ready_pct);
  end

  // Monitor: compares every output handshake against the queue head
  logic          prev_stall = 1'b0;
  logic [SB-1:0] prev_data = '0;
  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      prev_stall = 1'b0;
    end else begin
      logic [SB-1:0] e;
      int            c;
      if (m_axis_tvalid) valid_seen++;
      if (prev_stall) begin
        n_cmp++;
        if (!m_axis_tvalid || m_axis_tdata !== prev_data) begin
          n_err++;
          $display("FAIL hold: valid=%0b data=%h, required valid=1 data=%h",
                   m_axis_tvalid, m_axis_tdata, prev_data);
        end
      end
      if (!s_axis_tready) begin
        n_cmp++;
        if (!m_axis_tvalid) begin
          n_err++;
          $display("FAIL sready_low: s_tready=0 with m_tvalid=0, required m_tvalid=1");
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_beat: got %h, required no output", m_axis_tdata);
        end else begin
          e = exp_q.pop_front();
          c = exp_cyc_q.pop_front();
          if (m_axis_tdata !== e) begin
            n_err++;
            $display("FAIL data: got %h, required %h", m_axis_tdata, e);
          end
          if (chk_latency) begin
            n_cmp++;
            if (cyc != c + 1) begin
              n_err++;
              $display("FAIL latency: out at cycle %0d, required %0d", cyc, c + 1);
            end
          end
        end
        out_cnt++;
        if (out_cnt == 1) first_out = m_axis_tdata;
        last_out = m_axis_tdata;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
    end
  end

  // Driver tasks (called in the posedge+#1 phase, return in that phase)
  task automatic cfg_write(input logic [2:0] a, input int d);
    we = 1'b1; wa = a; wd = d;
    @(posedge ap_clk); #1;
    we = 1'b0;
  endtask

  task automatic program_cfg(input int xon, input int xoff, input int xend,
                             input int yon, input int yoff, input int yend);
    cfg_write(3'd0, xon);  cfg_write(3'd1, xoff); cfg_write(3'd2, xend);
    cfg_write(3'd4, yon);  cfg_write(3'd5, yoff); cfg_write(3'd6, yend);
    c_xon = xon; c_xoff = xoff; c_xend = xend;
    c_yon = yon; c_yoff = yoff; c_yend = yend;
  endtask

  task automatic send_beat(input logic [SB-1:0] d, input int idx, input int budget,
                           output bit ok);
    ok = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    for (int w = 0; w < budget; w++) begin
      @(negedge ap_clk);
      if (s_axis_tready) begin
        if (model_keep(idx)) begin
          exp_q.push_back(d);
          exp_cyc_q.push_back(cyc);
        end
        ok = 1'b1;
        @(posedge ap_clk); #1;
        break;
      end
      @(posedge ap_clk); #1;
    end
  endtask

  // Sends nfr frames back to back; data = beat index or a fixed random pattern
  task automatic send_frames(input bit use_idx, input int nfr);
    logic [SB-1:0] pat[];
    bit ok;
    int nb;
    nb  = frame_beats();
    pat = new[nb];
    for (int i = 0; i < nb; i++) pat[i] = use_idx ? SB'(i) : SB'($urandom);
    for (int f = 0; f < nfr; f++) begin
      for (int i = 0; i < nb; i++) begin
        send_beat(pat[i], i, 100, ok);
        if (!ok) begin
          check("input_accept_timeout", 0, 1);
          s_axis_tvalid = 1'b0;
          return;
        end
      end
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int w;
    w = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && w < budget) begin
      @(posedge ap_clk); #1;
      w++;
    end
    check("drain_done", (exp_q.size() == 0 && !m_axis_tvalid), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok_a, ok_b, ok_c;
    int t0;

    // Reset state
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    check("reset_m_tvalid", m_axis_tvalid, 0);
    check("reset_s_tready", s_axis_tready, 1);
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;

    // T1: cropped 6x6 frame, SF=2, always ready
    program_cfg(1, 5, 5, 1, 5, 5);
    ready_pct = 100; chk_latency = 1'b1; out_cnt = 0;
    repeat (2) @(posedge ap_clk); #1;
    send_frames(1'b1, 1);
    wait_drain(50);
    check("t1_count", out_cnt, 32);
    check("t1_first", first_out, 14);
    check("t1_last", last_out, 57);
    $display("T1 crop basic: %0d beats out", out_cnt);

    // T2: same frame with random backpressure
    ready_pct = 70; chk_latency = 1'b0; out_cnt = 0;
    send_frames(1'b1, 1);
    wait_drain(300);
    check("t2_count", out_cnt, 32);
    check("t2_last", last_out, 57);
    $display("T2 backpressure: %0d beats out", out_cnt);

    // T3: full window is a pass-through at one beat per clock
    program_cfg(0, 6, 5, 0, 6, 5);
    ready_pct = 100; chk_latency = 1'b1; out_cnt = 0;
    repeat (2) @(posedge ap_clk); #1;
    t0 = cyc;
    send_frames(1'b0, 1);
    check("t3_cycles", cyc - t0, 72);
    wait_drain(50);
    check("t3_count", out_cnt, 72);
    $display("T3 pass-through: %0d beats out", out_cnt);

    // T4: empty window with output stalled: everything consumed, nothing emitted
    program_cfg(3, 3, 5, 1, 5, 5);
    ready_pct = 0; chk_latency = 1'b0; out_cnt = 0; valid_seen = 0;
    repeat (2) @(posedge ap_clk); #1;
    t0 = cyc;
    send_frames(1'b0, 1);
    check("t4_cycles", cyc - t0, 72);
    repeat (3) @(posedge ap_clk); #1;
    check("t4_valid_seen", valid_seen, 0);
    $display("T4 empty window: valid seen %0d times", valid_seen);

    // T5: two back-to-back frames with identical content
    program_cfg(1, 5, 5, 1, 5, 5);
    ready_pct = 80; out_cnt = 0;
    repeat (2) @(posedge ap_clk); #1;
    send_frames(1'b0, 2);
    wait_drain(300);
    check("t5_count", out_cnt, 64);
    $display("T5 back-to-back: %0d beats out", out_cnt);

    // T6: reset with both buffers full in mid-frame
    ready_pct = 100; chk_latency = 1'b0;
    for (int i = 0; i < 20; i++) begin
      send_beat(SB'(i), i, 100, ok_a);
      if (!ok_a) check("t6_pre_accept", 0, 1);
    end
    s_axis_tvalid = 1'b0;
    wait_drain(50);
    ready_pct = 0;
    repeat (2) @(posedge ap_clk); #1;
    send_beat(SB'(20), 20, 5, ok_a);
    send_beat(SB'(21), 21, 5, ok_b);
    send_beat(SB'(22), 22, 3, ok_c);
    check("t6_accept_20_21", ok_a && ok_b, 1);
    check("t6_stall_22", ok_c, 0);
    check("t6_full_m_tvalid", m_axis_tvalid, 1);
    check("t6_full_s_tready", s_axis_tready, 0);
    #2;
    ap_rst_n = 1'b0;
    s_axis_tvalid = 1'b0;
    #1;
    check("t6_rst_m_tvalid", m_axis_tvalid, 0);
    check("t6_rst_s_tready", s_axis_tready, 1);
    exp_q.delete();
    exp_cyc_q.delete();
    repeat (2) @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    program_cfg(1, 5, 5, 1, 5, 5);
    ready_pct = 100; chk_latency = 1'b1; out_cnt = 0;
    repeat (2) @(posedge ap_clk); #1;
    send_frames(1'b1, 1);
    wait_drain(50);
    check("t6_count", out_cnt, 32);
    check("t6_first", first_out, 14);
    check("t6_last", last_out, 57);
    $display("T6 reset recovery: %0d beats out", out_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
